ladybird_aclint_responder: RTL
==============================

// Module: ladybird_aclint_responder
// PURPOSE
// - AXI4-Lite responder (slave) that answers core load/store traffic to the ACLINT window.
// - Implements MSIP, MTIMECMP and MTIME; drives the machine software and timer interrupts.
// - Sits on the core AXI bus beside ladybird_simulation_memory; the interconnect decodes the
//   window, so this block sees only offsets.
// PARAMETERS
// - AXI_ADDR_W  32      address width; only addr[15:0] is decoded
// - AXI_DATA_W  32      data width; only 32 is supported (elaboration error otherwise)
// - MSIP_OFS    'h0000  offset of MSIP word; bit0 is the only implemented bit
// - MTIMECMP_OFS 'h4000 offset of MTIMECMP lo word; hi word at +4
// - MTIME_OFS   'hBFF8  offset of MTIME lo word; hi word at +4
// PORTS
// - clk         in   1   clock
// - rst         in   1   asynchronous reset, active-high
// - rtc_tick    in   1   single-cycle pulse, clk-synchronous; MTIME += 1 per pulse
// - awvalid/awready  in/out 1   write address handshake
// - awaddr      in   AXI_ADDR_W   write address
// - wvalid/wready    in/out 1   write data handshake
// - wdata       in   32   write data
// - wstrb       in   4    byte strobes
// - bvalid/bready    out/in 1   write response handshake
// - bresp       out  2    write response (OKAY 2'b00, SLVERR 2'b10)
// - arvalid/arready  in/out 1   read address handshake
// - araddr      in   AXI_ADDR_W   read address
// - rvalid/rready    out/in 1   read data handshake
// - rdata       out  32   read data
// - rresp       out  2    read response
// - msip_irq    out  1    MSIP[0]
// - mtip_irq    out  1    (MTIME >= MTIMECMP), registered
// BEHAVIOUR
// - Reset: MSIP=0, MTIME=0, MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, all valid/ready outputs 0,
//   bresp/rresp/rdata=0, msip_irq=0, mtip_irq=0. Handshakes start 1 cycle after rst deasserts.
// - Write FSM W_IDLE -> W_RESP -> W_IDLE.
//   - W_IDLE: awready and wready are each high until their beat is captured; AW and W may
//     arrive in either order or in the same cycle.
//   - When both are held: the register updates on that edge (per-byte wstrb), the FSM enters
//     W_RESP and bvalid=1 on the next cycle.
//   - W_RESP: bvalid held until bready; both readies low. Returns to W_IDLE the cycle after
//     the B handshake.
// - Read FSM R_IDLE -> R_DATA -> R_IDLE.
//   - R_IDLE: arready=1; on the AR handshake rdata/rresp are registered and rvalid=1 next cycle.
//   - R_DATA: rdata held stable until rready; arready low.
// - Read and write FSMs are independent and may be active in the same cycle.
// - Decode uses addr[15:2] only; addr[1:0] are ignored.
//   - Unmapped offset: SLVERR, rdata=0, write dropped.
//   - Reserved MSIP bits read 0 and ignore writes.
// - MTIME update priority, same edge:
//   - a bus write to an MTIME half beats rtc_tick for that half;
//   - a tick carry into the un-written half is still applied.
// - MTIME wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
// - mtip_irq re-evaluates every cycle from the registered MTIME/MTIMECMP, so it reflects any
//   change one cycle later.
// - Writing MTIMECMP hi then lo can glitch mtip_irq; this is allowed.
// - rst asserted mid-transaction: the outstanding transfer is abandoned, the FSMs return to
//   idle, and no B/R beat is issued.
// CONFIGURATION
// - LADYBIRD_ACLINT_SNAPSHOT_EN defined:
//   - a read of MTIME lo latches MTIME[63:32] into a shadow register;
//   - the next read of MTIME hi returns the shadow (tear-free 64-bit read on RV32);
//   - the shadow is cleared to 0 at reset.
// - Not defined: the MTIME hi read returns live MTIME[63:32]; no shadow register exists.
// TESTING
// - After reset: read 'h4000 and 'h4004 -> 32'hFFFFFFFF both, OKAY; mtip_irq=0, msip_irq=0.
// - Write 'h0000 data 1 strb 4'hF with AW two cycles before W -> bvalid 1 cycle after W
//   accepted, OKAY; msip_irq=1. Write 0 -> msip_irq=0.
// - Set MTIMECMP=5 (hi=0 then lo=5), pulse rtc_tick 5 times -> mtip_irq rises exactly
//   1 cycle after MTIME reaches 5.
// - Write MTIME lo 'hFFFFFFFF, hi 0, then one tick -> MTIME reads lo=0, hi=1. With SNAPSHOT_EN,
//   a tick between the lo and hi reads still returns the hi latched at the lo read.
// - Read 'h1000 -> rresp=2'b10, rdata=0. Write 'h1000 -> bresp=2'b10, no state change.
// - Hold bready/rready low 10 cycles -> bvalid/rvalid and data stable, no new AW/AR
//   accepted; assert rst mid-hold -> valids drop asynchronously.

Source files
------------

// File: rtl/ladybird_aclint_responder_if.sv
// rtl/ladybird_aclint_responder_if.sv - AXI4-Lite bus bundle for the ACLINT responder
// Master drives requests and response-readies; slave drives request-readies and responses.
interface ladybird_aclint_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ladybird_aclint_responder.sv
// rtl/ladybird_aclint_responder.sv - AXI4-Lite ACLINT responder: MSIP, MTIMECMP, MTIME
// Define LADYBIRD_ACLINT_SNAPSHOT_EN for a tear-free MTIME hi read latched by the lo read.
module ladybird_aclint_responder #(
  parameter int          AXI_ADDR_W   = 32,
  parameter int          AXI_DATA_W   = 32,
  parameter logic [15:0] MSIP_OFS     = 16'h0000,
  parameter logic [15:0] MTIMECMP_OFS = 16'h4000,
  parameter logic [15:0] MTIME_OFS    = 16'hBFF8
) (
  input  logic clk,
  input  logic rst,
  input  logic rtc_tick,
  ladybird_aclint_responder_if.slave bus,
  output logic msip_irq,
  output logic mtip_irq
);

  generate
    if (AXI_DATA_W != 32) begin : g_bad_data_width
      $error("ladybird_aclint_responder supports only AXI_DATA_W == 32");
    end
  endgenerate

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [13:0] MSIP_W     = MSIP_OFS[15:2];
  localparam logic [13:0] CMP_LO_W   = MTIMECMP_OFS[15:2];
  localparam logic [13:0] CMP_HI_W   = MTIMECMP_OFS[15:2] + 14'd1;
  localparam logic [13:0] TIME_LO_W  = MTIME_OFS[15:2];
  localparam logic [13:0] TIME_HI_W  = MTIME_OFS[15:2] + 14'd1;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // One-hot select: {time_hi, time_lo, cmp_hi, cmp_lo, msip}; all zero means unmapped.
  function automatic logic [4:0] decode(input logic [13:0] word);
    logic [4:0] sel;
    sel    = 5'b0;
    sel[0] = (word == MSIP_W);
    sel[1] = (word == CMP_LO_W);
    sel[2] = (word == CMP_HI_W);
    sel[3] = (word == TIME_LO_W);
    sel[4] = (word == TIME_HI_W);
    return sel;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
    end
    return res;
  endfunction

  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_next;

  w_state_t    w_state;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_held;
  logic        w_held;
  logic [13:0] aw_word_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  r_state_t    r_state;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_fire;
  logic        w_fire;
  logic        ar_fire;
  logic        wr_en;
  logic [13:0] wr_word;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [4:0]  wsel;
  logic [4:0]  rsel;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [31:0] time_hi_rd;
  logic        unused_bits;

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign msip_irq    = msip;

  assign unused_bits = ^{bus.awaddr[AXI_ADDR_W-1:16], bus.awaddr[1:0],
                         bus.araddr[AXI_ADDR_W-1:16], bus.araddr[1:0]};

  assign aw_fire = bus.awvalid & awready_q;
  assign w_fire  = bus.wvalid & wready_q;
  assign ar_fire = bus.arvalid & arready_q;

  // A beat captured earlier wins over the live bus, which is then not being offered.
  assign wr_word = aw_held ? aw_word_q : bus.awaddr[15:2];
  assign wr_data = w_held ? w_data_q : bus.wdata;
  assign wr_strb = w_held ? w_strb_q : bus.wstrb;
  assign wr_en   = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
  assign wsel    = decode(wr_word);
  assign rsel    = decode(bus.araddr[15:2]);

  // A bus write owns its half; the tick carry still reaches the other half.
  always_comb begin
    logic [63:0] inc;
    inc        = rtc_tick ? mtime + 64'd1 : mtime;
    mtime_next = inc;
    if (wr_en && wsel[3]) mtime_next[31:0]  = merge(mtime[31:0], wr_data, wr_strb);
    if (wr_en && wsel[4]) mtime_next[63:32] = merge(mtime[63:32], wr_data, wr_strb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip     <= 1'b0;
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_irq <= 1'b0;
    end else begin
      if (wr_en && wsel[0] && wr_strb[0]) msip <= wr_data[0];
      if (wr_en && wsel[1]) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wr_data, wr_strb);
      if (wr_en && wsel[2]) mtimecmp[63:32] <= merge(mtimecmp[63:32], wr_data, wr_strb);
      mtime    <= mtime_next;
      mtip_irq <= (mtime >= mtimecmp);
    end
  end

`ifdef LADYBIRD_ACLINT_SNAPSHOT_EN
  logic [31:0] shadow_hi;
  logic        shadow_armed;

  // The lo read arms the shadow; the following hi read consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hi    <= 32'd0;
      shadow_armed <= 1'b0;
    end else if (ar_fire) begin
      if (rsel[3]) begin
        shadow_hi    <= mtime[63:32];
        shadow_armed <= 1'b1;
      end else if (rsel[4]) begin
        shadow_armed <= 1'b0;
      end
    end
  end

  assign time_hi_rd = shadow_armed ? shadow_hi : mtime[63:32];
`else
  assign time_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rd_data = 32'd0;
    rd_resp = RESP_OKAY;
    if (rsel[0])      rd_data = {31'd0, msip};
    else if (rsel[1]) rd_data = mtimecmp[31:0];
    else if (rsel[2]) rd_data = mtimecmp[63:32];
    else if (rsel[3]) rd_data = mtime[31:0];
    else if (rsel[4]) rd_data = time_hi_rd;
    else              rd_resp = RESP_SLVERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word_q <= 14'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_en) begin
            w_state   <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= (|wsel) ? RESP_OKAY : RESP_SLVERR;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
          end else begin
            if (aw_fire) begin
              aw_held   <= 1'b1;
              aw_word_q <= bus.awaddr[15:2];
            end
            if (w_fire) begin
              w_held   <= 1'b1;
              w_data_q <= bus.wdata;
              w_strb_q <= bus.wstrb;
            end
            awready_q <= ~(aw_held | aw_fire);
            wready_q  <= ~(w_held | w_fire);
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
